yuv422_to_ycbcr444: RTL and testbench



---
 rtl/yuv_pkg.sv | 12 +
 rtl/yuv422_to_ycbcr444_sync_delay.sv | 20 ++
 rtl/yuv422_to_ycbcr444.sv | 79 +++++++
 tb/tb_yuv422_to_ycbcr444.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/yuv_pkg.sv
// yuv_pkg: shared phase type, widths, defaults and rounding average for the 4:2:2 upsampler
package yuv_pkg;
  localparam int PIX_W = 8;
  localparam int LATENCY_C = 3;
  localparam logic [PIX_W-1:0] NEUTRAL_C_DEF = 8'd128;
  typedef enum logic {EVEN, ODD} phase_t;
  function automatic logic [PIX_W-1:0] avg(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{PIX_W{1'b0}}, 1'b1};
    return s[PIX_W:1];
  endfunction
endpackage

// File: rtl/yuv422_to_ycbcr444_sync_delay.sv
// sync_delay: DEPTH-stage shift register for sync/qualifier bits, async active-low reset to 0
module sync_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sr [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/yuv422_to_ycbcr444.sv
// yuv422_to_ycbcr444: 4:2:2 to 4:4:4 upsampler, 3-clock latency; define CHROMA_INTERP_EN to interpolate Cb on ODD pixels
module yuv422_to_ycbcr444
  import yuv_pkg::*;
#(
  parameter bit               CB_FIRST  = 1'b1,
  parameter logic [PIX_W-1:0] NEUTRAL_C = NEUTRAL_C_DEF,
  localparam int              LATENCY   = LATENCY_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      i_yc_16b,
  input  logic             i_h_sync,
  input  logic             i_v_sync,
  input  logic             i_data_en,
  output logic [PIX_W-1:0] o_y_8b,
  output logic [PIX_W-1:0] o_cb_8b,
  output logic [PIX_W-1:0] o_cr_8b,
  output logic             o_h_sync,
  output logic             o_v_sync,
  output logic             o_data_en
);
  phase_t phase, s1_ph, s2_ph;
  logic s1_de, s2_de;
  logic [PIX_W-1:0] s1_y, s1_c, s2_y, s2_c;
  logic [PIX_W-1:0] mate_c, even_cb, even_cr, odd_cb;
  logic [2:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase <= EVEN;
      s1_ph <= EVEN;
      s2_ph <= EVEN;
      s1_de <= 1'b0;
      s2_de <= 1'b0;
      s1_y  <= '0;
      s1_c  <= '0;
      s2_y  <= '0;
      s2_c  <= '0;
    end else begin
      phase <= (i_data_en && phase == EVEN) ? ODD : EVEN;
      s1_ph <= phase;
      s1_de <= i_data_en;
      s1_y  <= i_yc_16b[15:8];
      s1_c  <= i_yc_16b[7:0];
      s2_ph <= s1_ph;
      s2_de <= s1_de;
      s2_y  <= s1_y;
      s2_c  <= s1_c;
    end
  // An EVEN pixel in stage 2 sees its ODD partner in stage 1, or nothing if the line ended.
  assign mate_c  = s1_de ? s1_c : NEUTRAL_C;
  assign even_cb = CB_FIRST ? s2_c : mate_c;
  assign even_cr = CB_FIRST ? mate_c : s2_c;
`ifdef CHROMA_INTERP_EN
  logic [PIX_W-1:0] next_cb;
  // ODD pixel: output regs still hold its pair's chroma; Cb of the next pair is in stage 1 or at the input.
  assign next_cb = CB_FIRST ? (s1_de ? s1_c : o_cb_8b)
                            : ((s1_de && i_data_en) ? i_yc_16b[7:0] : o_cb_8b);
  assign odd_cb  = avg(o_cb_8b, next_cb);
`else
  assign odd_cb  = o_cb_8b;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_y_8b  <= '0;
      o_cb_8b <= '0;
      o_cr_8b <= '0;
    end else begin
      o_y_8b  <= s2_de ? s2_y : '0;
      o_cb_8b <= !s2_de ? '0 : (s2_ph == EVEN) ? even_cb : odd_cb;
      o_cr_8b <= !s2_de ? '0 : (s2_ph == EVEN) ? even_cr : o_cr_8b;
    end
  sync_delay #(.DEPTH(LATENCY), .WIDTH(3)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({i_h_sync, i_v_sync, i_data_en}),
    .q    (sync_q)
  );
  assign {o_h_sync, o_v_sync, o_data_en} = sync_q;
endmodule

// File: tb/tb_yuv422_to_ycbcr444.sv
// tb_yuv422_to_ycbcr444: random and directed stimulus against a line-level reference model, both CB_FIRST settings
module tb_yuv422_to_ycbcr444;
  localparam int LAT = 3;
  localparam logic [7:0] NEUTRAL = 8'd128;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] yc = '0;
  logic h = 1'b0, v = 1'b0, de = 1'b0;
  logic [7:0] y1, cb1, cr1, y0, cb0, cr0;
  logic h1, v1, de1, h0, v0, de0;
  int vectors = 0, errors = 0;
  bit sde[$], sh[$], sv[$];
  logic [7:0] sy[$], sc[$];
  always #5 clk = ~clk;
  yuv422_to_ycbcr444 #(.CB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_yc_16b(yc), .i_h_sync(h), .i_v_sync(v), .i_data_en(de),
    .o_y_8b(y1), .o_cb_8b(cb1), .o_cr_8b(cr1), .o_h_sync(h1), .o_v_sync(v1), .o_data_en(de1));
  yuv422_to_ycbcr444 #(.CB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_yc_16b(yc), .i_h_sync(h), .i_v_sync(v), .i_data_en(de),
    .o_y_8b(y0), .o_cb_8b(cb0), .o_cr_8b(cr0), .o_h_sync(h0), .o_v_sync(v0), .o_data_en(de0));
  task automatic check(string tag, logic [26:0] got, logic [26:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(int y, int c, bit d, bit hh = 1'b0, bit vv = 1'b0);
    sy.push_back(8'(y));
    sc.push_back(8'(c));
    sde.push_back(d);
    sh.push_back(hh);
    sv.push_back(vv);
  endtask
  // Expected {h,v,de,y,cb,cr} for input index i, derived from the pixel's place within its run of active pixels.
  function automatic logic [26:0] model(int i, bit cbf);
    int s, e, pos, base, nb;
    logic [7:0] ce, co, cb, cr;
    if (i < 0) return '0;
    if (!sde[i]) return {sh[i], sv[i], 1'b0, 24'd0};
    s = i;
    while (s > 0 && sde[s-1]) s--;
    e = i;
    while (e + 1 < sde.size() && sde[e+1]) e++;
    pos  = i - s;
    base = s + (pos / 2) * 2;
    ce = sc[base];
    co = (base + 1 <= e) ? sc[base+1] : NEUTRAL;
    cb = cbf ? ce : co;
    cr = cbf ? co : ce;
`ifdef CHROMA_INTERP_EN
    if (pos % 2 == 1) begin
      nb = base + 2 + (cbf ? 0 : 1);
      if (nb <= e) cb = 8'((int'(cb) + int'(sc[nb]) + 1) / 2);
    end
`else
    nb = 0;
`endif
    return {sh[i], sv[i], 1'b1, sy[i], cb, cr};
  endfunction
  task automatic run_seq(string tag);
    for (int k = 0; k < 4; k++) push(0, 0, 1'b0);
    for (int j = 0; j < sde.size(); j++) begin
      yc = {sy[j], sc[j]};
      de = sde[j];
      h  = sh[j];
      v  = sv[j];
      @(posedge clk);
      #1;
      check({tag, "/cbf1"}, {h1, v1, de1, y1, cb1, cr1}, model(j - LAT + 1, 1'b1));
      check({tag, "/cbf0"}, {h0, v0, de0, y0, cb0, cr0}, model(j - LAT + 1, 1'b0));
    end
    sy.delete();
    sc.delete();
    sde.delete();
    sh.delete();
    sv.delete();
  endtask
  task automatic rand_line(int n);
    for (int k = 0; k < n; k++)
      push($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 5) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask
  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      yc = 16'($urandom);
      de = 1'b1;
      h  = 1'b1;
      v  = 1'b1;
      @(posedge clk);
      #1;
      check("reset_cbf1", {h1, v1, de1, y1, cb1, cr1}, '0);
      check("reset_cbf0", {h0, v0, de0, y0, cb0, cr0}, '0);
    end
    @(negedge clk);
    de = 1'b0;
    h  = 1'b0;
    v  = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("idle_cbf1", {h1, v1, de1, y1, cb1, cr1}, '0);
      check("idle_cbf0", {h0, v0, de0, y0, cb0, cr0}, '0);
    end
    push(10, 40, 1); push(20, 200, 1); push(30, 50, 1); push(40, 210, 1);
    run_seq("repl4");
    push(10, 40, 1); push(20, 200, 1); push(30, 50, 1);
    run_seq("odd3");
    push(10, 200, 1); push(20, 40, 1); push(0, 0, 0); push(30, 200, 1); push(40, 40, 1); push(50, 60, 1);
    run_seq("gap");
    push(5, 40, 1, 1, 0); push(6, 90, 1, 0, 1); push(7, 50, 1, 1, 1); push(8, 70, 1); push(0, 0, 0, 1, 1);
    run_seq("interp");
    for (int r = 0; r < 8; r++) begin
      rand_line(50);
      run_seq("rand");
    end
    for (int k = 0; k < 4; k++) begin
      yc = {8'(10 * (k + 1)), 8'(60 + k)};
      de = 1'b1;
      h  = 1'(k);
      v  = 1'b1;
      @(posedge clk);
      #1;
    end
    check("midrst_pre", {19'd0, y1}, 27'd20);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cbf1", {h1, v1, de1, y1, cb1, cr1}, '0);
    check("midrst_cbf0", {h0, v0, de0, y0, cb0, cr0}, '0);
    @(negedge clk);
    @(negedge clk);
    de = 1'b0;
    h  = 1'b0;
    v  = 1'b0;
    rst_n = 1'b1;
    rand_line(40);
    run_seq("postrst");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
